// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI transaction arbiter
//   BYTE_W      - width of one SPI transfer
//   arb_state_t - arbiter FSM states
package spi_arb_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LOW,
        WAIT_HIGH,
        RESP,
        HOLD
    } arb_state_t;
endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational round-robin picker
//   req   - request vector
//   ptr   - highest-priority index, search runs upward with wrap
//   idx   - winning requester index
//   valid - at least one request present
module spi_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);
    // Scan offsets from farthest to nearest so the nearest request to ptr wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one SPI byte engine among NUM_REQ requesters
//   clk, rst       - clock, asynchronous active-high reset
//   req/req_data/req_last - per-requester request level, TX byte, burst end
//   gnt, ack       - one-hot owner and one-cycle completion pulse
//   rsp_data/rsp_err - received byte and timeout flag, valid with ack
//   busy           - arbiter not idle
//   drv_start/drv_data - start pulse and TX byte to the engine
//   drv_en_n/drv_rx - engine active-low enable and received byte
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [BYTE_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      drv_start,
    output logic [BYTE_W-1:0]         drv_data,
    input  logic                      drv_en_n,
    input  logic [BYTE_W-1:0]         drv_rx
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t       state, next;
    logic [IDX_W-1:0] owner, ptr, nxt_ptr, pick_idx;
    logic             pick_vld, last_q, timed_out, done, abort;
    logic [CNT_W-1:0] cnt;

    spi_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    assign nxt_ptr   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign timed_out = cnt >= CNT_W'(TIMEOUT - 1);
    assign done      = (state == WAIT_HIGH) && drv_en_n;
    // A late falling edge in WAIT_LOW still moves on; only a stalled wait aborts.
    assign abort     = timed_out && (((state == WAIT_LOW) && drv_en_n) ||
                                     ((state == WAIT_HIGH) && !drv_en_n));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:      next = pick_vld ? LAUNCH : IDLE;
            LAUNCH:    next = WAIT_LOW;
            WAIT_LOW:  next = !drv_en_n ? WAIT_HIGH : (abort ? RESP : WAIT_LOW);
            WAIT_HIGH: next = (done || abort) ? RESP : WAIT_HIGH;
            RESP:      next = (!last_q && !rsp_err) ? HOLD : IDLE;
            HOLD:      next = req[owner] ? LAUNCH : IDLE;
            default:   next = IDLE;
        endcase
    end

    always_comb begin
        busy      = state != IDLE;
        drv_start = state == LAUNCH;
        gnt       = (state != IDLE) ? NUM_REQ'(1) << owner : '0;
        ack       = (state == RESP) ? NUM_REQ'(1) << owner : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= '0;
            ptr      <= '0;
            last_q   <= 1'b0;
            cnt      <= '0;
            drv_data <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_vld) begin
                    owner    <= pick_idx;
                    drv_data <= req_data[int'(pick_idx)*BYTE_W +: BYTE_W];
                    last_q   <= req_last[pick_idx];
                end
                LAUNCH: cnt <= '0;
                WAIT_LOW, WAIT_HIGH: begin
                    cnt <= cnt + 1'b1;
                    if (done) begin
                        rsp_data <= drv_rx;
                        rsp_err  <= 1'b0;
                    end else if (abort) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        last_q   <= 1'b1;
                    end
                end
                RESP: if (last_q || rsp_err) ptr <= nxt_ptr;
                HOLD: if (req[owner]) begin
                    drv_data <= req_data[int'(owner)*BYTE_W +: BYTE_W];
                    last_q   <= req_last[owner];
                end else begin
                    ptr <= nxt_ptr;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed self-checking bench for spi_txn_arbiter
module tb_spi_txn_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_last, gnt, ack;
    logic [31:0] req_data;
    logic [7:0]  rsp_data, drv_data, drv_rx;
    logic        rsp_err, busy, drv_start, drv_en_n;
    logic        eng_on;
    logic [3:0]  ec;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  eg;
        logic [7:0]  etx;
        logic [7:0]  erx;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    spi_txn_arbiter #(.NUM_REQ(4), .TIMEOUT(16), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .gnt(gnt), .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .drv_start(drv_start), .drv_data(drv_data), .drv_en_n(drv_en_n), .drv_rx(drv_rx)
    );

    // Engine model: enable low for four cycles starting two edges after start,
    // returning the TX byte XOR 0x99.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ec       <= 4'd0;
            drv_en_n <= 1'b1;
            drv_rx   <= 8'd0;
        end else if (drv_start && eng_on) begin
            ec <= 4'd1;
        end else if (ec != 4'd0) begin
            if (ec == 4'd1) drv_rx <= drv_data ^ 8'h99;
            drv_en_n <= (ec == 4'd5);
            ec       <= (ec == 4'd5) ? 4'd0 : ec + 4'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        chk("ack_owner", 32'(ack & ~gnt), 32'd0);
    end

    task automatic wait_start(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!drv_start && c < 40);
        if (!drv_start) c = -1;
    endtask

    task automatic wait_ack(output int c, output logic p1, output logic p2);
        c  = 0;
        p1 = drv_en_n;
        p2 = 1'b1;
        forever begin
            @(negedge clk);
            c++;
            if (ack != 4'd0) break;
            if (c >= 60) begin
                c = -1;
                break;
            end
            p2 = p1;
            p1 = drv_en_n;
        end
    endtask

    task automatic xfer(input logic [3:0] eg, input logic [7:0] etx, input logic [7:0] erx,
                        input logic eerr, input int slat, input int alat);
        int   c;
        logic p1, p2;
        wait_start(c);
        chk("start_lat", 32'(c), 32'(slat));
        chk("gnt", 32'(gnt), 32'(eg));
        chk("drv_data", 32'(drv_data), 32'(etx));
        chk("busy", 32'(busy), 32'd1);
        wait_ack(c, p1, p2);
        chk("ack_lat", 32'(c), 32'(alat));
        chk("ack", 32'(ack), 32'(eg));
        chk("rsp_data", 32'(rsp_data), 32'(erx));
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        if (!eerr) chk("en_rise", 32'({p2, p1}), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_chk(input string nm);
        @(negedge clk);
        chk(nm, 32'({busy, gnt, ack}), 32'd0);
    endtask

    initial begin
        logic [31:0] fw;
        logic [7:0]  frx[4];
        int          c;
        fw  = 32'h44332211;
        frx = '{8'h88, 8'hBB, 8'hAA, 8'hDD};
        tbl[0] = '{4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5, 8'h3C};
        tbl[1] = '{4'b0011, 32'h0000_7712, 4'b0001, 8'h12, 8'h8B};
        tbl[2] = '{4'b0011, 32'h0000_5634, 4'b0010, 8'h56, 8'hCF};
        tbl[3] = '{4'b1001, 32'hF000_0001, 4'b1000, 8'hF0, 8'h69};
        tbl[4] = '{4'b1000, 32'h0F00_0000, 4'b1000, 8'h0F, 8'h96};
        tbl[5] = '{4'b0110, 32'h00C3_3C00, 4'b0010, 8'h3C, 8'hA5};
        rst = 1'b1; req = '0; req_last = '1; req_data = '0; eng_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outs", 32'({gnt, ack, busy, drv_start, rsp_err}), 32'd0);
        chk("reset_data", 32'({drv_data, rsp_data}), 32'd0);
        rst = 1'b0;

        // Single transfers, round-robin pointer carried between rows
        for (int i = 0; i < 6; i++) begin
            req      = tbl[i].req;
            req_data = tbl[i].data;
            req_last = 4'hF;
            xfer(tbl[i].eg, tbl[i].etx, tbl[i].erx, 1'b0, 1, 7);
            req = '0;
            idle_chk("tbl_idle");
        end

        // Fairness with all requesters held
        do_reset();
        req = 4'hF; req_data = fw; req_last = 4'hF;
        for (int k = 0; k < 5; k++)
            xfer(4'd1 << (k % 4), fw[8*(k%4) +: 8], frx[k%4], 1'b0, (k == 0) ? 1 : 2, 7);
        req = '0;
        idle_chk("fair_idle");

        // Burst lock: requester 1 sends three bytes while 0 waits
        do_reset();
        req = 4'b0001; req_data = 32'h0000_0055; req_last = 4'hF;
        xfer(4'b0001, 8'h55, 8'hCC, 1'b0, 1, 7);
        req = 4'b0011; req_data = 32'h0000_A155; req_last = 4'b1101;
        xfer(4'b0010, 8'hA1, 8'h38, 1'b0, 2, 7);
        req_data = 32'h0000_B255;
        @(negedge clk);
        chk("hold_gnt1", 32'({busy, gnt}), 32'b10010);
        xfer(4'b0010, 8'hB2, 8'h2B, 1'b0, 1, 7);
        req_data = 32'h0000_C355; req_last = 4'hF;
        @(negedge clk);
        chk("hold_gnt2", 32'({busy, gnt}), 32'b10010);
        xfer(4'b0010, 8'hC3, 8'h5A, 1'b0, 1, 7);
        req = 4'b0001;
        xfer(4'b0001, 8'h55, 8'hCC, 1'b0, 2, 7);
        req = '0;
        idle_chk("burst_idle");

        // Lock release: owner 3 drops req right after ack
        do_reset();
        req = 4'b1000; req_data = 32'h7E00_1D00; req_last = 4'b0111;
        xfer(4'b1000, 8'h7E, 8'hE7, 1'b0, 1, 7);
        req = 4'b0110; req_last = 4'hF;
        @(negedge clk);
        chk("rel_hold", 32'({busy, gnt}), 32'b11000);
        idle_chk("rel_idle");
        xfer(4'b0010, 8'h1D, 8'h84, 1'b0, 1, 7);
        req = '0;
        idle_chk("rel_done");

        // Timeout: engine ignores the start pulse
        eng_on = 1'b0;
        req = 4'b0100; req_data = 32'h0099_0000; req_last = 4'b1011;
        xfer(4'b0100, 8'h99, 8'h00, 1'b1, 1, 17);
        req = '0;
        idle_chk("tmo_unlock");
        eng_on = 1'b1;

        // Reset during WAIT_HIGH, then fresh grant from pointer 0
        req = 4'b1010; req_data = 32'h6000_4200; req_last = 4'hF;
        wait_start(c);
        chk("mid_gnt", 32'(gnt), 32'b1000);
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'({busy, drv_en_n}), 32'b10);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", 32'({gnt, ack, busy, drv_start, rsp_err}), 32'd0);
        chk("mid_rst_data", 32'({drv_data, rsp_data}), 32'd0);
        @(negedge clk);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        xfer(4'b0010, 8'h42, 8'hDB, 1'b0, 1, 7);
        req = '0;
        idle_chk("end_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
